// File: rtl/hamming_encode_stream_pkg.sv
// Shared SECDED geometry helpers for the streaming encoder
// and the matching decoder.
package hamming_encode_stream_pkg;

  function automatic int code_bits(input int dw);
    int r;
    r = 0;
    for (int i = 8; i >= 1; i--)
      if ((1 << i) >= dw + i + 1) r = i;
    return r;
  endfunction

  function automatic int coded_width(input int dw);
    return dw + code_bits(dw) + 1;
  endfunction

  function automatic bit is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Data index held at codeword position pos, -1 for parity slots.
  function automatic int data_index(input int pos);
    int n;
    if (pos <= 0 || is_pow2(pos)) return -1;
    n = 0;
    for (int i = 1; i < pos; i++)
      if (!is_pow2(i)) n++;
    return n;
  endfunction

  function automatic logic [255:0] par_mask(input int k, input int cw);
    logic [255:0] m;
    m = '0;
    for (int p = 1; p < 256; p++)
      if (p < cw && ((p >> k) & 1) == 1) m = m | (256'(1) << p);
    return m;
  endfunction

endpackage

// File: rtl/hamming_encode_stream_if.sv
// Stream, injection and statistics bundle between
// producer/consumer and the encoder.
interface hamming_encode_stream_if
  import hamming_encode_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  localparam int CB = code_bits(DATA_WIDTH);
  localparam int CW = coded_width(DATA_WIDTH);
  localparam int PW = $clog2(CW);

  logic [DATA_WIDTH-1:0] data_in_i;
  logic                  valid_in_i;
  logic                  ready_out_o;
  logic                  inj_en_i;
  logic                  inj_double_i;
  logic [PW-1:0]         inj_pos_i;
  logic [CW-1:0]         data_out_o;
  logic [CB:0]           parity_bits_o;
  logic                  valid_out_o;
  logic                  ready_in_i;
  logic [CNT_WIDTH-1:0]  word_count_o;
  logic [CNT_WIDTH-1:0]  inj_count_o;

  modport master (
    output data_in_i, valid_in_i, inj_en_i,
    output inj_double_i, inj_pos_i, ready_in_i,
    input  ready_out_o, data_out_o, parity_bits_o,
    input  valid_out_o, word_count_o, inj_count_o
  );

  modport slave (
    input  data_in_i, valid_in_i, inj_en_i,
    input  inj_double_i, inj_pos_i, ready_in_i,
    output ready_out_o, data_out_o, parity_bits_o,
    output valid_out_o, word_count_o, inj_count_o
  );
endinterface

// File: rtl/hamming_secded_core.sv
// Combinational SECDED encoder: data -> {codeword, parity}.
// Shared with the decoder for syndrome generation.
module hamming_secded_core
  import hamming_encode_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int CB = code_bits(DATA_WIDTH),
  localparam int CW = coded_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CW-1:0]         codeword_o,
  output logic [CB:0]           parity_o
);

  logic [CW-1:1] dbits;
  logic [CW-1:1] hcw;
  logic [CB-1:0] hp;

  for (genvar p = 1; p < CW; p++) begin : g_pos
    if (is_pow2(p)) begin : g_par
      localparam int K = $clog2(p);
      assign dbits[p] = 1'b0;
      assign hcw[p]   = hp[K];
    end else begin : g_dat
      localparam int DI = data_index(p);
      assign dbits[p] = data_i[DI];
      assign hcw[p]   = data_i[DI];
    end
  end

  // Parity slots are zero in dbits, so each check sees data only.
  for (genvar k = 0; k < CB; k++) begin : g_chk
    localparam logic [255:0] M = par_mask(k, CW);
    assign hp[k] = ^(dbits & M[CW-1:1]);
  end

  assign codeword_o = {hcw, ^hcw};
  assign parity_o   = {hp, ^hcw};

endmodule

// File: rtl/hamming_encode_stream.sv
// Two-stage streaming SECDED encoder with error injection
// and delivered/injected word counters.
module hamming_encode_stream
  import hamming_encode_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk_i,
  input logic rst_n_i,
  hamming_encode_stream_if.slave bus
);

  localparam int CB = code_bits(DATA_WIDTH);
  localparam int CW = coded_width(DATA_WIDTH);
  localparam int PW = $clog2(CW);

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_inj_en_q, s1_inj_en_d;
  logic                  s1_inj_dbl_q, s1_inj_dbl_d;
  logic [PW-1:0]         s1_pos_q, s1_pos_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [CW-1:0]         s2_data_q, s2_data_d;
  logic [CB:0]           s2_par_q, s2_par_d;
  logic                  s2_inj_q, s2_inj_d;

  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0]  inj_cnt_q, inj_cnt_d;

  logic                  s1_load;
  logic                  s2_load;
  logic                  out_hs;
  logic [CW-1:0]         cw_clean;
  logic [CB:0]           par_clean;
  logic [31:0]           pos_ext;
  logic [PW-1:0]         pos2;
  logic                  inj_hit;
  logic [CW-1:0]         flip;

  hamming_secded_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .data_i    (s1_data_q),
    .codeword_o(cw_clean),
    .parity_o  (par_clean)
  );

  assign s2_load = s1_valid_q & (~s2_valid_q | bus.ready_in_i);
  assign bus.ready_out_o = ~s1_valid_q | s2_load;
  assign s1_load = bus.valid_in_i & bus.ready_out_o;
  assign out_hs  = s2_valid_q & bus.ready_in_i;

  assign pos_ext = 32'(s1_pos_q);
  assign inj_hit = s1_inj_en_q & (pos_ext < CW);
  assign pos2    = (pos_ext == CW - 1) ? '0 : s1_pos_q + 1'b1;

  always_comb begin
    flip = '0;
    if (inj_hit) begin
      flip[s1_pos_q] = 1'b1;
      if (s1_inj_dbl_q) flip[pos2] = 1'b1;
    end
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_data_d    = s1_data_q;
    s1_inj_en_d  = s1_inj_en_q;
    s1_inj_dbl_d = s1_inj_dbl_q;
    s1_pos_d     = s1_pos_q;
    if (s1_load) begin
      s1_valid_d   = 1'b1;
      s1_data_d    = bus.data_in_i;
      s1_inj_en_d  = bus.inj_en_i;
      s1_inj_dbl_d = bus.inj_double_i;
      s1_pos_d     = bus.inj_pos_i;
    end else if (s2_load) begin
      s1_valid_d   = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_par_d   = s2_par_q;
    s2_inj_d   = s2_inj_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_data_d  = cw_clean ^ flip;
      s2_par_d   = par_clean;
      s2_inj_d   = inj_hit;
    end else if (bus.ready_in_i) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    inj_cnt_d  = inj_cnt_q;
    if (out_hs) begin
      word_cnt_d = word_cnt_q + 1'b1;
      if (s2_inj_q) inj_cnt_d = inj_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_inj_en_q  <= 1'b0;
      s1_inj_dbl_q <= 1'b0;
      s1_pos_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_par_q     <= '0;
      s2_inj_q     <= 1'b0;
      word_cnt_q   <= '0;
      inj_cnt_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_inj_en_q  <= s1_inj_en_d;
      s1_inj_dbl_q <= s1_inj_dbl_d;
      s1_pos_q     <= s1_pos_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_par_q     <= s2_par_d;
      s2_inj_q     <= s2_inj_d;
      word_cnt_q   <= word_cnt_d;
      inj_cnt_q    <= inj_cnt_d;
    end
  end

  assign bus.valid_out_o   = s2_valid_q;
  assign bus.data_out_o    = s2_data_q;
  assign bus.parity_bits_o = s2_par_q;
  assign bus.word_count_o  = word_cnt_q;
  assign bus.inj_count_o   = inj_cnt_q;

endmodule

// File: doc/hamming_encode_stream.md
# hamming_encode_stream

Streaming SECDED Hamming encoder: the parametrised successor of the single-register encoder. Adds a full valid/ready handshake with backpressure, a two-stage pipeline, per-word error injection for downstream decoder verification, and word/injection counters. Sits between a producer and the storage/link write path; its output feeds memory or the decoder under test.

## Interface
- DATA_WIDTH, 32: payload bits, legal range 4..247.
- CNT_WIDTH, 16: width of the statistics counters.
- Derived: CODE_BITS = smallest r with 2^r >= DATA_WIDTH+r+1 (6 for 32); CODED_WIDTH = DATA_WIDTH+CODE_BITS+1 (39); POS_WIDTH = $clog2(CODED_WIDTH).
- clk_i  in  1  single clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- data_in_i  in  DATA_WIDTH  payload.
- valid_in_i  in  1  payload valid.
- ready_out_o  out  1  encoder can accept this cycle.
- inj_en_i  in  1  inject error into this word (sampled with the data).
- inj_double_i  in  1  inject two-bit error instead of one.
- inj_pos_i  in  POS_WIDTH  codeword bit to flip.
- data_out_o  out  CODED_WIDTH  codeword.
- parity_bits_o  out  CODE_BITS+1  {hamming parity[CODE_BITS-1:0], overall parity}.
- valid_out_o  out  1  codeword valid.
- ready_in_i  in  1  downstream accepts.
- word_count_o  out  CNT_WIDTH  codewords delivered.
- inj_count_o  out  CNT_WIDTH  codewords delivered with injection applied.

## Operation
- Codeword layout: bit 0 = overall (extended) parity; bits 1..CODED_WIDTH-1 = Hamming positions; parity bit k at position 2^k; data bits fill non-power-of-two positions in ascending order, LSB first.
- Parity k = XOR of all positions whose index has bit k set; overall parity = XOR of positions 1..CODED_WIDTH-1.
- parity_bits_o always reports the clean (pre-injection) parity.
- Injection: flip bit inj_pos_i of the codeword; if inj_double_i, also flip (inj_pos_i+1) mod CODED_WIDTH. inj_pos_i >= CODED_WIDTH: no flip, word not counted as injected. Injection controls ignored unless inj_en_i.
- Stage 1 (S1): registers data and injection controls on an input handshake (valid_in_i & ready_out_o).
- Stage 2 (S2): registers encoded, injected codeword and parity.
- S2 loads when S1 valid and (S2 empty or ready_in_i). S1 loads when S1 empty or S1 moves to S2 this cycle. ready_out_o = !S1_valid | S1 advances (combinational from ready_in_i).
- word_count_o increments on each output handshake (valid_out_o & ready_in_i); inj_count_o also increments if that word was injected. Both wrap.

## Timing
- Reset: S1/S2 valids 0, valid_out_o 0, data_out_o 0, parity_bits_o 0, both counters 0; ready_out_o 1 when reset releases.
- Latency: word accepted in cycle N appears on valid_out_o in cycle N+2 with ready_in_i held high.
- Throughput: one word per cycle, no bubbles, when ready_in_i is high.
- Stall: valid_out_o and data_out_o stay stable while valid_out_o & !ready_in_i. At most 2 words held; third blocked via ready_out_o = 0.
- Simultaneous output handshake and input handshake on full pipeline: both complete, order preserved.
- Reset asserted mid-stream: in-flight words discarded immediately, no partial output.

## Structure
- Add to gray_area_package: functions computing CODE_BITS/CODED_WIDTH from DATA_WIDTH, and a codeword-position-to-data-index mapping function, shared with the decoder.
- Sub-module hamming_secded_core: purely combinational data -> {codeword, parity}; instantiated between S1 and S2, reused by the decoder for syndrome generation.

## Test plan
- DATA_WIDTH=32, data 0x00000000, no injection -> data_out_o 0, parity_bits_o 0, valid_out_o 2 cycles after accept.
- Data 0x00000001 -> data_out_o 39'h0F (bits 0-3 set), parity_bits_o 7'h07.
- Back-to-back 8 words with ready_in_i=1 -> 8 consecutive output cycles, in order, word_count_o = 8.
- 4 words sent while ready_in_i=0 for 5 cycles -> ready_out_o drops after 2 accepted; outputs stable while stalled; all 4 delivered in order after release.
- Data 0x1, inj_en_i=1, inj_pos_i=5 -> data_out_o 39'h2F, parity_bits_o 7'h07, inj_count_o = 1; inj_double_i=1, inj_pos_i=38 -> bits 38 and 0 flipped; inj_pos_i=40 -> clean word, inj_count_o unchanged.
- Reset asserted with 2 words in flight -> valid_out_o 0 immediately, counters 0, no stale word after release.
